aes_dec_round_ctrl: RTL and testbench

Iterative AES inverse-cipher sequencer. It accepts one 128-bit ciphertext, reuses a single external inverse round datapath over NR-1 cycles, and produces the plaintext. The datapath per cycle is AddRoundKey, then InvMixColumns, then InvShiftRows, then InvSubBytes. The block owns the state register and round counter, performs the first stage (AddRoundKey with key NR, then InvShiftRows and InvSubBytes, no InvMixColumns) and the final AddRoundKey with key 0 internally, and fetches round keys by index from an external key store.

---
 rtl/aes_dec_round_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_aes_dec_round_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_dec_round_ctrl
//
// Iterative AES inverse-cipher sequencer. One 128-bit ciphertext is loaded into
// the internal state register. The first stage (AddRoundKey with key NR, then
// InvShiftRows and InvSubBytes) is done here. The NR-1 middle rounds reuse an
// external inverse round datapath. The last AddRoundKey (key 0) is also done
// here, and the plaintext is held until the consumer takes it.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    ciphertext offered
//   in_ready    block is idle and will accept a ciphertext
//   in_data     ciphertext (byte 0 in bits [127:120], column-major state)
//   key_idx     round-key index requested from the external key store
//   round_key   key store output for key_idx (combinational, same cycle)
//   rnd_data    round datapath data_in (the state register)
//   rnd_key     round datapath key_in (round_key passed through)
//   rnd_result  round datapath data_out
//   out_valid   plaintext available
//   out_ready   consumer accepts plaintext
//   out_data    plaintext
//   busy        high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module aes_dec_round_ctrl #(
    parameter int NR  = 10,
    parameter int KIW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    output logic [KIW-1:0] key_idx,
    input  logic [127:0]   round_key,
    output logic [127:0]   rnd_data,
    output logic [127:0]   rnd_key,
    input  logic [127:0]   rnd_result,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_data,
    output logic           busy
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL,
        DONE
    } state_e;

    state_e         state_q,     state_d;
    logic [KIW-1:0] round_cnt_q, round_cnt_d;
    logic [127:0]   state_reg_q, state_reg_d;
    logic [127:0]   out_data_q,  out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q,  in_ready_d;
    logic           busy_q,      busy_d;
    logic [127:0]   init_val;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = x;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Row r of the column-major state rotates right by r byte positions.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r) & 3)) -: 8];
            end
        end
        return o;
    endfunction

    // First stage has no InvMixColumns, so it is done locally instead of
    // through the external round datapath.
    assign init_val = inv_sub_bytes(inv_shift_rows(state_reg_q ^ round_key));

    always_comb begin
        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        state_reg_d = state_reg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        key_idx     = KIW'(NR);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_reg_d = in_data;
                    state_d     = INIT;
                end
            end
            INIT: begin
                state_reg_d = init_val;
                round_cnt_d = KIW'(NR - 1);
                state_d     = ROUND;
            end
            ROUND: begin
                key_idx     = round_cnt_q;
                state_reg_d = rnd_result;
                // Counter stops at 1 so it can never wrap below the last round.
                if (round_cnt_q == KIW'(1)) begin
                    state_d = FINAL;
                end else begin
                    round_cnt_d = round_cnt_q - KIW'(1);
                end
            end
            FINAL: begin
                key_idx     = '0;
                out_data_d  = state_reg_q ^ round_key;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are registered from the next state so they line up
        // with the state they describe.
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            round_cnt_q <= '0;
            state_reg_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
            state_reg_q <= state_reg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign rnd_data  = state_reg_q;
    assign rnd_key   = round_key;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_dec_round_ctrl
//
// Bench for aes_dec_round_ctrl. Two instances: NR=10 (AES-128) and NR=14
// (AES-256). The bench provides the key store (its own key expansion) and the
// external inverse round datapath. Plaintexts come from published AES vectors.
// -----------------------------------------------------------------------------
module tb_aes_dec_round_ctrl;

    localparam int NR_A = 10;
    localparam int NR_B = 14;
    localparam int KIW  = 4;

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic           in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [127:0]   in_data_a, round_key_a, rnd_data_a, rnd_key_a, rnd_result_a, out_data_a;
    logic [KIW-1:0] key_idx_a;

    logic           in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [127:0]   in_data_b, round_key_b, rnd_data_b, rnd_key_b, rnd_result_b, out_data_b;
    logic [KIW-1:0] key_idx_b;

    logic [7:0]   sbox  [0:255];
    logic [7:0]   isbox [0:255];
    logic [127:0] ks_a  [0:15];
    logic [127:0] ks_b  [0:15];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [127:0] exp_q [$];
    int           acc_q [$];
    int           acc_hist [$];
    logic [127:0] cur_exp;

    typedef struct packed {
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;
    vec_t vecs [0:2];
    int   trace_exp [0:11];

    aes_dec_round_ctrl #(.NR(NR_A), .KIW(KIW)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_a),
        .in_ready   (in_ready_a),
        .in_data    (in_data_a),
        .key_idx    (key_idx_a),
        .round_key  (round_key_a),
        .rnd_data   (rnd_data_a),
        .rnd_key    (rnd_key_a),
        .rnd_result (rnd_result_a),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready_a),
        .out_data   (out_data_a),
        .busy       (busy_a)
    );

    aes_dec_round_ctrl #(.NR(NR_B), .KIW(KIW)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_b),
        .in_ready   (in_ready_b),
        .in_data    (in_data_b),
        .key_idx    (key_idx_b),
        .round_key  (round_key_b),
        .rnd_data   (rnd_data_b),
        .rnd_key    (rnd_key_b),
        .rnd_result (rnd_result_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready_b),
        .out_data   (out_data_b),
        .busy       (busy_b)
    );

    // ---------------- reference helpers ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul4(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xt(x);
        end
        return acc;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    // One inverse round: AddRoundKey, InvMixColumns, InvShiftRows, InvSubBytes.
    function automatic logic [127:0] model_round(input logic [127:0] d, input logic [127:0] k);
        logic [127:0] x;
        logic [127:0] o;
        logic [7:0]   s [0:15];
        logic [7:0]   m [0:15];
        x = d ^ k;
        o = '0;
        for (int i = 0; i < 16; i++) s[i] = x[127 - 8*i -: 8];
        for (int c = 0; c < 4; c++) begin
            m[4*c]   = mul4(s[4*c], 4'he) ^ mul4(s[4*c+1], 4'hb) ^ mul4(s[4*c+2], 4'hd) ^ mul4(s[4*c+3], 4'h9);
            m[4*c+1] = mul4(s[4*c], 4'h9) ^ mul4(s[4*c+1], 4'he) ^ mul4(s[4*c+2], 4'hb) ^ mul4(s[4*c+3], 4'hd);
            m[4*c+2] = mul4(s[4*c], 4'hd) ^ mul4(s[4*c+1], 4'h9) ^ mul4(s[4*c+2], 4'he) ^ mul4(s[4*c+3], 4'hb);
            m[4*c+3] = mul4(s[4*c], 4'hb) ^ mul4(s[4*c+1], 4'hd) ^ mul4(s[4*c+2], 4'h9) ^ mul4(s[4*c+3], 4'he);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = isbox[m[r + 4*((c + 4 - r) % 4)]];
            end
        end
        return o;
    endfunction

    assign round_key_a  = ks_a[key_idx_a];
    assign round_key_b  = ks_b[key_idx_b];
    assign rnd_result_a = model_round(rnd_data_a, rnd_key_a);
    assign rnd_result_b = model_round(rnd_data_b, rnd_key_b);

    // Forward S-box via the 3 / (1/3) generator walk, inverse by table flip.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
    endtask

    task automatic expand(input logic [255:0] key, input int nk, input int nr, input bit to_b);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (to_b) ks_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else      ks_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual=bound expired required=event", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [127:0] ct, input logic [127:0] pt);
        int  n0;
        bit  ok;
        n0         = acc_hist.size();
        ok         = 1'b0;
        in_data_a  = ct;
        cur_exp    = pt;
        in_valid_a = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (acc_hist.size() > n0) ok = 1'b1;
        end
        in_valid_a = 1'b0;
        if (!ok) fail_bound("send_accept");
    endtask

    task automatic drain_a();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (exp_q.size() == 0 && !out_valid_a) ok = 1'b1;
            else step();
        end
        if (!ok) fail_bound("drain_output");
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor for instance A; looks half a cycle before each edge.
    initial begin
        int   ov_rise_cyc;
        logic ov_prev;
        int   a;
        ov_rise_cyc = 0;
        ov_prev     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                acc_q.delete();
                ov_prev = 1'b0;
            end else begin
                if (in_valid_a && in_ready_a) begin
                    exp_q.push_back(cur_exp);
                    acc_q.push_back(cyc);
                    acc_hist.push_back(cyc);
                end
                if (out_valid_a && !ov_prev) ov_rise_cyc = cyc;
                if (out_valid_a && out_ready_a) begin
                    if (exp_q.size() == 0) begin
                        fail_bound("sb_unexpected_output");
                    end else begin
                        chk("sb_out_data", out_data_a, exp_q.pop_front());
                        a = acc_q.pop_front();
                        chk("sb_latency", 128'(ov_rise_cyc - a), 128'(NR_A + 2));
                    end
                end
                ov_prev = out_valid_a;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=time limit required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found;
        logic [127:0] held;

        vecs[0] = '{key: C1_KEY, ct: C1_CT, pt: C_PT};
        vecs[1] = '{key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    ct: 128'h3925841d02dc09fbdc118597196a0b32,
                    pt: 128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    ct: 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                    pt: 128'h6bc1bee22e409f96e93d7e117393172a};
        for (int i = 0; i < 12; i++) begin
            if (i < 2)       trace_exp[i] = NR_A;
            else if (i < 11) trace_exp[i] = 11 - i;
            else             trace_exp[i] = 0;
        end

        for (int i = 0; i < 16; i++) begin
            ks_a[i] = '0;
            ks_b[i] = '0;
        end
        build_sbox();
        rst_n       = 1'b0;
        in_valid_a  = 1'b0;
        in_data_a   = '0;
        out_ready_a = 1'b0;
        in_valid_b  = 1'b0;
        in_data_b   = '0;
        out_ready_b = 1'b0;
        cur_exp     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid_a), 128'(0));
        chk("rst_busy", 128'(busy_a), 128'(0));
        chk("rst_out_data", out_data_a, 128'h0);
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", 128'(in_ready_a), 128'(1));
        chk("idle_busy", 128'(busy_a), 128'(0));
        chk("idle_key_idx", 128'(key_idx_a), 128'(NR_A));
        chk("idle_out_valid", 128'(out_valid_a), 128'(0));

        // C.1 run with key_idx trace, latency and backpressure
        expand(C1_KEY, 4, NR_A, 1'b0);
        in_data_a  = C1_CT;
        cur_exp    = C_PT;
        in_valid_a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("trace_key_idx_%0d", i), 128'(key_idx_a), 128'(trace_exp[i]));
            chk($sformatf("trace_out_valid_low_%0d", i), 128'(out_valid_a), 128'(0));
            step();
            in_valid_a = 1'b0;
            in_data_a  = '1;
        end
        chk("c1_out_valid_at_12", 128'(out_valid_a), 128'(1));
        chk("c1_out_data", out_data_a, C_PT);
        held = out_data_a;
        for (int i = 0; i < 20; i++) begin
            in_valid_a = (i % 3 == 0);
            in_data_a  = {$urandom, $urandom, $urandom, $urandom};
            cur_exp    = '1;
            chk("bp_out_data_stable", out_data_a, held);
            chk("bp_out_valid", 128'(out_valid_a), 128'(1));
            chk("bp_in_ready", 128'(in_ready_a), 128'(0));
            step();
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        step();
        out_ready_a = 1'b0;
        chk("bp_release_in_ready", 128'(in_ready_a), 128'(1));
        chk("bp_release_busy", 128'(busy_a), 128'(0));
        chk("bp_release_out_valid", 128'(out_valid_a), 128'(0));
        chk("bp_release_key_idx", 128'(key_idx_a), 128'(NR_A));

        // Table-driven vectors through the scoreboard
        out_ready_a = 1'b1;
        for (int v = 0; v < 3; v++) begin
            expand(vecs[v].key, 4, NR_A, 1'b0);
            send_a(vecs[v].ct, vecs[v].pt);
            drain_a();
        end

        // Back-to-back with in_valid held high
        expand(C1_KEY, 4, NR_A, 1'b0);
        acc_hist.delete();
        in_data_a  = C1_CT;
        cur_exp    = C_PT;
        in_valid_a = 1'b1;
        found      = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (acc_hist.size() >= 2) found = 1'b1;
        end
        in_valid_a = 1'b0;
        if (!found) fail_bound("b2b_second_accept");
        else chk("b2b_accept_spacing", 128'(acc_hist[1] - acc_hist[0]), 128'(NR_A + 3));
        drain_a();

        // Reset in the middle of ROUND (round_cnt = 5)
        out_ready_a = 1'b0;
        send_a(C1_CT, C_PT);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (key_idx_a == KIW'(5) && busy_a) found = 1'b1;
            else step();
        end
        if (!found) fail_bound("midrst_reach_round5");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid_a), 128'(0));
        chk("midrst_busy", 128'(busy_a), 128'(0));
        chk("midrst_out_data", out_data_a, 128'h0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        step();
        chk("midrst_after_in_ready", 128'(in_ready_a), 128'(1));
        chk("midrst_after_out_valid", 128'(out_valid_a), 128'(0));
        out_ready_a = 1'b1;
        send_a(C1_CT, C_PT);
        drain_a();
        out_ready_a = 1'b0;

        // NR=14 instance, AES-256 C.3
        expand(C3_KEY, 8, NR_B, 1'b1);
        step();
        chk("c3_idle_key_idx", 128'(key_idx_b), 128'(NR_B));
        in_data_b  = C3_CT;
        in_valid_b = 1'b1;
        for (int i = 0; i < NR_B + 2; i++) begin
            chk($sformatf("c3_out_valid_low_%0d", i), 128'(out_valid_b), 128'(0));
            step();
            in_valid_b = 1'b0;
        end
        chk("c3_out_valid_at_16", 128'(out_valid_b), 128'(1));
        chk("c3_out_data", out_data_b, C_PT);
        out_ready_b = 1'b1;
        step();
        out_ready_b = 1'b0;
        chk("c3_release_in_ready", 128'(in_ready_b), 128'(1));
        chk("c3_release_busy", 128'(busy_b), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
